// File: rtl/program_counter_if.sv
// Fetch-stage PC bus: pipeline control in, current/successor address out.
interface program_counter_if #(
   parameter int WIDTH = 32
);
   logic             count;
   logic             shouldUseNewPC;
   logic [WIDTH-1:0] newPC;
   logic [WIDTH-1:0] pcAddress;
   logic [WIDTH-1:0] nextPCAddress;

   // Driven by pipeline control, observes the PC.
   modport master (
      output count, shouldUseNewPC, newPC,
      input  pcAddress, nextPCAddress
   );

   // The PC register itself.
   modport slave (
      input  count, shouldUseNewPC, newPC,
      output pcAddress, nextPCAddress
   );
endinterface

// File: rtl/program_counter.sv
// Fetch-stage program counter: holds, steps by INCREMENT, or loads a redirect.
module program_counter #(
   parameter int               WIDTH      = 32,
   parameter logic [WIDTH-1:0] RESET_ADDR = 32'h0040_0000,
   parameter int unsigned      INCREMENT  = 4
) (
   input logic               clk,
   input logic               rst,
   program_counter_if.slave  bus
);
   localparam logic [WIDTH-1:0] STEP = WIDTH'(INCREMENT);

   logic [WIDTH-1:0] pc_q;
   logic [WIDTH-1:0] pc_d;
   logic [WIDTH-1:0] seq_pc;

   // Successor address; unsigned add wraps modulo 2^WIDTH.
   assign seq_pc = pc_q + STEP;

   // Next-state select: newPC is only looked at when a redirect is taken,
   // so an unknown target on a stall or sequential step cannot leak in.
   always_comb begin
      pc_d = pc_q;
      if (bus.count) begin
         if (bus.shouldUseNewPC) pc_d = bus.newPC;
         else                    pc_d = seq_pc;
      end
   end

   // PC register; reset wins over every other input.
   always_ff @(posedge clk) begin
      if (rst) pc_q <= RESET_ADDR;
      else     pc_q <= pc_d;
   end

   assign bus.pcAddress     = pc_q;
   assign bus.nextPCAddress = seq_pc;
endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter: directed vector table plus a
// randomized run against a reference model, both scored through a queue.
module tb_program_counter;
   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   program_counter_if #(.WIDTH(32)) bus ();

   program_counter #(
      .WIDTH(32), .RESET_ADDR(32'h0040_0000), .INCREMENT(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        r;
      logic        cnt;
      logic        use_new;
      logic [31:0] npc;
      logic [31:0] exp_pc;
      string       name;
   } vec_t;

   vec_t        vecs[14];
   logic [31:0] exp_q[$];
   logic [31:0] model_pc;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs at the falling edge, queue the expected PC,
   // then compare shortly after the rising edge.
   task automatic step(input string name, input logic r, input logic c,
                       input logic u, input logic [31:0] npc, input logic [31:0] exp_pc);
      logic [31:0] e;
      @(negedge clk);
      rst = r; bus.count = c; bus.shouldUseNewPC = u; bus.newPC = npc;
      exp_q.push_back(exp_pc);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         checks++; failures++;
         $display("FAIL %s: scoreboard empty", name);
      end else begin
         e = exp_q.pop_front();
         check({name, ".pc"},   bus.pcAddress,     e);
         check({name, ".next"}, bus.nextPCAddress, e + 32'd4);
         checks++;
         if ($isunknown({bus.pcAddress, bus.nextPCAddress})) begin
            failures++;
            $display("FAIL %s.xcheck: outputs unknown pc=%h next=%h", name,
                     bus.pcAddress, bus.nextPCAddress);
         end
      end
   endtask

   initial begin
      vecs[0]  = '{1'b1, 1'b1, 1'b0, 32'hxxxx_xxxx, 32'h0040_0000, "reset"};
      vecs[1]  = '{1'b0, 1'b1, 1'b0, 32'hxxxx_xxxx, 32'h0040_0004, "adv1"};
      vecs[2]  = '{1'b0, 1'b1, 1'b0, 32'hxxxx_xxxx, 32'h0040_0008, "adv2"};
      vecs[3]  = '{1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'h0040_0008, "stall"};
      vecs[4]  = '{1'b0, 1'b1, 1'b0, 32'hxxxx_xxxx, 32'h0040_000C, "adv3"};
      vecs[5]  = '{1'b0, 1'b1, 1'b1, 32'h0040_0100, 32'h0040_0100, "redirect"};
      vecs[6]  = '{1'b0, 1'b0, 1'b1, 32'h0040_0200, 32'h0040_0100, "redir_stall"};
      vecs[7]  = '{1'b0, 1'b1, 1'b1, 32'h0000_0003, 32'h0000_0003, "unaligned"};
      vecs[8]  = '{1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, "wrap_load"};
      vecs[9]  = '{1'b0, 1'b1, 1'b0, 32'hxxxx_xxxx, 32'h0000_0000, "wrap_adv"};
      vecs[10] = '{1'b0, 1'b1, 1'b0, 32'h1111_1111, 32'h0000_0004, "adv_ignore"};
      vecs[11] = '{1'b1, 1'b1, 1'b1, 32'h1234_5678, 32'h0040_0000, "midrst"};
      vecs[12] = '{1'b0, 1'b1, 1'b1, 32'h8000_0000, 32'h8000_0000, "redirect2"};
      vecs[13] = '{1'b1, 1'b0, 1'b0, 32'hxxxx_xxxx, 32'h0040_0000, "rst_stall"};

      rst = 1'b1; bus.count = 1'b0; bus.shouldUseNewPC = 1'b0; bus.newPC = '0;

      for (int i = 0; i < 14; i++)
         step(vecs[i].name, vecs[i].r, vecs[i].cnt, vecs[i].use_new,
              vecs[i].npc, vecs[i].exp_pc);

      // Held reset across several edges stays at the reset address.
      step("rst_hold1", 1'b1, 1'b1, 1'b1, 32'hAAAA_AAAA, 32'h0040_0000);
      step("rst_hold2", 1'b1, 1'b1, 1'b0, 32'h5555_5555, 32'h0040_0000);

      // Back-to-back redirects then a stall run.
      step("bb_redir1", 1'b0, 1'b1, 1'b1, 32'h0000_1000, 32'h0000_1000);
      step("bb_redir2", 1'b0, 1'b1, 1'b1, 32'h0000_2000, 32'h0000_2000);
      for (int i = 0; i < 3; i++)
         step("stall_run", 1'b0, 1'b0, 1'b0, 32'h0000_9999, 32'h0000_2000);
      step("after_stall", 1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_2004);

      // Randomized run against a reference model.
      model_pc = 32'h0000_2004;
      for (int i = 0; i < 300; i++) begin
         logic r, c, u;
         logic [31:0] n;
         r = ($urandom_range(0, 19) == 0);
         c = $urandom_range(0, 3) != 0;
         u = $urandom_range(0, 3) == 0;
         n = $urandom;
         if (r)           model_pc = 32'h0040_0000;
         else if (c && u) model_pc = n;
         else if (c)      model_pc = model_pc + 32'd4;
         step("rand", r, c, u, n, model_pc);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/program_counter.md
Name: program_counter

Overview:
- 32-bit program counter register for the CPU fetch stage.
- Holds the current instruction address and presents it to instruction memory.
- Combinationally provides the sequential successor address (PC+4).
- Each clock it either holds (stall), advances by 4, or loads a redirect target (branch/jump) supplied by later pipeline logic.

Parameters:
- WIDTH, 32, address width in bits.
- RESET_ADDR, 32'h0040_0000, value loaded on reset (start of text segment).
- INCREMENT, 4, byte step between sequential instructions.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- count  input  1  advance enable. 1 = update PC this cycle; 0 = hold (stall).
- shouldUseNewPC  input  1  redirect select. 1 = load newPC instead of PC+4 (only when count=1).
- newPC  input  WIDTH  redirect target address.
- pcAddress  output  WIDTH  current PC (registered).
- nextPCAddress  output  WIDTH  pcAddress + INCREMENT (combinational).

Behaviour:
- Single register pc_q drives pcAddress directly; no other state.
- Reset: on a rising clk edge with rst=1, pc_q <= RESET_ADDR.
  - Reset dominates count and shouldUseNewPC.
  - pcAddress = 32'h0040_0000 after the reset edge.
  - Reset asserted mid-run returns to RESET_ADDR on the next edge regardless of other inputs.
- Rising edge with rst=0, priority order:
  - count=0: pc_q holds. shouldUseNewPC and newPC are ignored and may be X.
  - count=1, shouldUseNewPC=1: pc_q <= newPC, loaded verbatim with no alignment masking.
  - count=1, shouldUseNewPC=0: pc_q <= pc_q + INCREMENT. newPC is ignored and may be X without corrupting pc_q.
- nextPCAddress = pcAddress + INCREMENT, purely combinational.
  - Valid in the same cycle pcAddress changes; zero latency.
  - Independent of count and shouldUseNewPC.
- Arithmetic: unsigned, modulo 2^WIDTH.
  - 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000 in both pc_q and nextPCAddress.
  - No overflow flag.
- Latency: count/shouldUseNewPC/newPC sampled at edge N are visible on pcAddress immediately after edge N (one-cycle register latency).
- Outputs never X once reset has been applied, even when newPC is X and unselected.
- Before the first reset edge, pc_q is undefined; the design does not rely on an initial value.

Test Plan:
- Reset: assert rst for one edge, count=1, shouldUseNewPC=0, newPC=X -> pcAddress=32'h0040_0000, nextPCAddress=32'h0040_0004.
- Sequential advance: rst=0, count=1, shouldUseNewPC=0, three edges -> pcAddress 32'h0040_0004, then 32'h0040_0008, then 32'h0040_000C; nextPCAddress always pcAddress+4.
- Stall: at pcAddress=32'h0040_0008, count=0 for one edge -> pcAddress stays 32'h0040_0008, nextPCAddress 32'h0040_000C; next edge with count=1 -> 32'h0040_000C.
- Redirect: count=1, shouldUseNewPC=1, newPC=32'h0040_0100 -> pcAddress=32'h0040_0100, nextPCAddress=32'h0040_0104. Same inputs with count=0 -> pcAddress unchanged.
- Wrap: newPC=32'hFFFF_FFFC loaded -> nextPCAddress=32'h0000_0000; next sequential edge -> pcAddress=32'h0000_0000.
- Mid-run reset: rst=1 together with count=1, shouldUseNewPC=1, newPC=32'h1234_5678 -> pcAddress=32'h0040_0000.
